// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions for the command master.
//   htrans_t / hsize_t  : bus encodings
//   HBURST_SINGLE, HPROT_DEFAULT, HRESP_OKAY/ERROR : fixed bus values
//   clamp_size()        : limits a requested HSIZE to the data bus width
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'd0,
        HSIZE_HALF  = 3'd1,
        HSIZE_WORD  = 3'd2,
        HSIZE_DWORD = 3'd3,
        HSIZE_4W    = 3'd4,
        HSIZE_8W    = 3'd5,
        HSIZE_16W   = 3'd6,
        HSIZE_32W   = 3'd7
    } hsize_t;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DEFAULT = 4'b0011;
    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;

    function automatic hsize_t clamp_size(input logic [2:0] size, input logic [2:0] max_size);
        return (size > max_size) ? hsize_t'(max_size) : hsize_t'(size);
    endfunction

endpackage

// File: rtl/ahb_wait_watchdog.sv
// Data-phase wait watchdog.
//   clk, rstn : clock, async active-low reset
//   d_valid   : a data phase is open
//   hready    : slave HREADYOUT
//   timeout   : sticky, set once WAIT_LIMIT consecutive wait cycles are seen
module ahb_wait_watchdog #(
    parameter int WAIT_LIMIT = 16
) (
    input  logic clk,
    input  logic rstn,
    input  logic d_valid,
    input  logic hready,
    output logic timeout
);

    localparam int CW = $clog2(WAIT_LIMIT + 1);

    logic [CW-1:0] cnt;

    // Counter saturates at the limit so a very long stall cannot wrap it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt     <= '0;
            timeout <= 1'b0;
        end else if (d_valid && !hready) begin
            if (cnt != CW'(WAIT_LIMIT)) cnt <= cnt + CW'(1);
            if (cnt == CW'(WAIT_LIMIT - 1)) timeout <= 1'b1;
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/ahb_cmd_master.sv
// AHB-Lite single-master front end: valid/ready commands -> SINGLE transfers.
//   cmd_*      : command stream (accepted when cmd_valid && cmd_ready)
//   rsp_*      : one in-order response pulse per completed data phase
//   H*         : AHB-Lite master signals to/from the slave
//   busy       : a command is held or a data phase is open
//   timeout    : sticky watchdog flag for long data-phase waits
// Two slots pipeline the bus: A holds the address phase, D the data phase.
module ahb_cmd_master
    import ahb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int WAIT_LIMIT = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [2:0]        cmd_size,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              HSEL,
    output logic [ADDR_W-1:0] HADDR,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    output logic [3:0]        HPROT,
    output logic [1:0]        HTRANS,
    output logic              HMASTLOCK,
    output logic [DATA_W-1:0] HWDATA,
    input  logic              HREADY,
    input  logic              HRESP,
    input  logic [DATA_W-1:0] HRDATA,
    output logic              busy,
    output logic              timeout
);

    localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_W / 8));

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        hsize_t            size;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    cmd_t              a_q;
    cmd_t              cmd_in;
    hsize_t            cmd_sz;
    logic              a_valid;
    logic              d_valid;
    logic              d_write;
    logic [DATA_W-1:0] d_wdata;
    logic              err_hold;
    logic              accept;
    logic              a_adv;
    htrans_t           htrans;

    // Normalise the incoming command: clamp size, then clear sub-size address bits.
    always_comb begin
        cmd_sz       = clamp_size(cmd_size, MAX_SIZE);
        cmd_in.write = cmd_write;
        cmd_in.size  = cmd_sz;
        cmd_in.addr  = cmd_addr & ~((ADDR_W'(1) << cmd_sz) - ADDR_W'(1));
        cmd_in.wdata = cmd_wdata;
    end

    // During err_hold the address phase is cancelled, so A cannot advance.
    assign a_adv     = a_valid && HREADY && !err_hold;
    assign cmd_ready = !a_valid || (HREADY && !err_hold);
    assign accept    = cmd_valid && cmd_ready;
    assign htrans    = (a_valid && !err_hold) ? HTRANS_NONSEQ : HTRANS_IDLE;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a_valid   <= 1'b0;
            a_q       <= '0;
            d_valid   <= 1'b0;
            d_write   <= 1'b0;
            d_wdata   <= '0;
            err_hold  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                a_q     <= cmd_in;
                a_valid <= 1'b1;
            end else if (a_adv) begin
                a_valid <= 1'b0;
            end

            if (HREADY) begin
                d_valid <= a_adv;
                if (a_adv) begin
                    d_write <= a_q.write;
                    d_wdata <= a_q.wdata;
                end
            end

            rsp_valid <= d_valid && HREADY;
            if (d_valid && HREADY) begin
                rsp_err   <= (HRESP == HRESP_ERROR);
                rsp_rdata <= d_write ? '0 : HRDATA;
            end

            // First ERROR cycle arms the cancel; the second (HREADY=1) releases it.
            if (d_valid && !HREADY && (HRESP == HRESP_ERROR)) err_hold <= 1'b1;
            else if (HREADY)                                   err_hold <= 1'b0;
        end
    end

    ahb_wait_watchdog #(
        .WAIT_LIMIT (WAIT_LIMIT)
    ) u_wdog (
        .clk     (clk),
        .rstn    (rstn),
        .d_valid (d_valid),
        .hready  (HREADY),
        .timeout (timeout)
    );

    assign HTRANS    = htrans;
    assign HSEL      = htrans[1];
    assign HADDR     = a_q.addr;
    assign HWRITE    = a_q.write;
    assign HSIZE     = a_q.size;
    assign HWDATA    = d_wdata;
    assign HBURST    = HBURST_SINGLE;
    assign HPROT     = HPROT_DEFAULT;
    assign HMASTLOCK = 1'b0;
    assign busy      = a_valid || d_valid;

endmodule

// File: tb/tb_ahb_cmd_master.sv
module tb_ahb_cmd_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int WL = 16;
    localparam int MAXSZ = 2;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [2:0]    cmd_size = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic          HSEL, HWRITE, HMASTLOCK;
    logic [AW-1:0] HADDR;
    logic [2:0]    HSIZE, HBURST;
    logic [3:0]    HPROT;
    logic [1:0]    HTRANS;
    logic [DW-1:0] HWDATA;
    logic          HREADY = 1'b1, HRESP = 1'b0;
    logic [DW-1:0] HRDATA = '0;
    logic          busy, timeout;

    always #5 clk = ~clk;

    ahb_cmd_master #(.ADDR_W(AW), .DATA_W(DW), .WAIT_LIMIT(WL)) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK),
        .HWDATA(HWDATA), .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA),
        .busy(busy), .timeout(timeout)
    );

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: commands wait in iss_q until the bus takes
    // their address phase, then sit in dat_q until their data phase ends.
    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [2:0]  s;
        logic [31:0] d;
    } xfer_t;

    xfer_t       iss_q[$];
    xfer_t       dat_q[$];
    bit          err_m, tmo_m, rv_m, re_m;
    logic [31:0] rd_m;
    int          wcnt;

    always @(negedge clk) begin
        bit    nonseq, rdy, dv;
        xfer_t c;
        if (!rstn) begin
            iss_q.delete(); dat_q.delete();
            err_m = 0; tmo_m = 0; rv_m = 0; re_m = 0; rd_m = '0; wcnt = 0;
            chk("rst HTRANS", HTRANS, 0);
            chk("rst HSEL", HSEL, 0);
            chk("rst HADDR", HADDR, 0);
            chk("rst HWRITE", HWRITE, 0);
            chk("rst HSIZE", HSIZE, 0);
            chk("rst HWDATA", HWDATA, 0);
            chk("rst rsp_valid", rsp_valid, 0);
            chk("rst rsp_rdata", rsp_rdata, 0);
            chk("rst rsp_err", rsp_err, 0);
            chk("rst busy", busy, 0);
            chk("rst timeout", timeout, 0);
        end else begin
            nonseq = (iss_q.size() != 0) && !err_m;
            rdy    = (iss_q.size() == 0) || (HREADY && !err_m);
            dv     = dat_q.size() != 0;
            chk("cmd_ready", cmd_ready, rdy);
            chk("HTRANS", HTRANS, nonseq ? 2'b10 : 2'b00);
            chk("HSEL", HSEL, nonseq);
            if (nonseq) begin
                chk("HADDR", HADDR, iss_q[0].a);
                chk("HWRITE", HWRITE, iss_q[0].w);
                chk("HSIZE", HSIZE, iss_q[0].s);
            end
            if (dv && dat_q[0].w) chk("HWDATA", HWDATA, dat_q[0].d);
            chk("rsp_valid", rsp_valid, rv_m);
            if (rv_m) begin
                chk("rsp_rdata", rsp_rdata, rd_m);
                chk("rsp_err", rsp_err, re_m);
            end
            chk("busy", busy, (iss_q.size() != 0) || dv);
            chk("timeout", timeout, tmo_m);
            chk("HBURST", HBURST, 3'b000);
            chk("HPROT", HPROT, 4'b0011);
            chk("HMASTLOCK", HMASTLOCK, 0);

            // Inputs are stable until the next rising edge: advance the model across it.
            if (dv && !HREADY) begin
                wcnt++;
                if (wcnt >= WL) tmo_m = 1;
            end else begin
                wcnt = 0;
            end
            if (dv && HRESP && !HREADY) err_m = 1;
            else if (HREADY)            err_m = 0;
            rv_m = dv && HREADY;
            if (rv_m) begin
                re_m = HRESP;
                rd_m = dat_q[0].w ? 32'h0 : HRDATA;
                void'(dat_q.pop_front());
            end
            if (nonseq && HREADY) dat_q.push_back(iss_q.pop_front());
            if (cmd_valid && rdy) begin
                c.w = cmd_write;
                c.s = (cmd_size > 3'(MAXSZ)) ? 3'(MAXSZ) : cmd_size;
                c.a = cmd_addr & ~((32'd1 << c.s) - 32'd1);
                c.d = cmd_wdata;
                iss_q.push_back(c);
            end
        end
    end

    // Pass one rising edge, set the inputs for the following edge, then stop
    // at the falling edge where outputs show the state after the edge passed.
    task automatic go(input bit cv, input bit cw, input logic [31:0] ca, input logic [2:0] cs,
                      input logic [31:0] cwd, input bit hr, input bit hrsp, input logic [31:0] hrd);
        @(posedge clk); #1;
        cmd_valid = cv; cmd_write = cw; cmd_addr = ca; cmd_size = cs; cmd_wdata = cwd;
        HREADY = hr; HRESP = hrsp; HRDATA = hrd;
        @(negedge clk);
    endtask

    task automatic nop(input int n);
        repeat (n) go(0, 0, 0, 0, 0, 1, 0, 0);
    endtask

    initial begin
        #50000;
        $display("FAIL global time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        chk("cmd_ready after reset", cmd_ready, 1);
        nop(1);

        // Single read, zero wait: NONSEQ after accept, response 3 cycles later.
        go(1, 0, 32'h10, 3'd2, 0, 1, 0, 32'hDEADBEEF);
        go(0, 0, 0, 0, 0, 1, 0, 32'hDEADBEEF);
        chk("t1 nonseq", HTRANS, 2'b10);
        chk("t1 haddr", HADDR, 32'h10);
        go(0, 0, 0, 0, 0, 1, 0, 32'hDEADBEEF);
        chk("t1 no early rsp", rsp_valid, 0);
        go(0, 0, 0, 0, 0, 1, 0, 32'hDEADBEEF);
        chk("t1 rsp_valid", rsp_valid, 1);
        chk("t1 rsp_rdata", rsp_rdata, 32'hDEADBEEF);
        chk("t1 rsp_err", rsp_err, 0);
        go(0, 0, 0, 0, 0, 1, 0, 0);
        chk("t1 rsp pulse", rsp_valid, 0);
        nop(1);

        // Four back-to-back writes.
        for (int i = 0; i < 7; i++) begin
            if (i < 4) go(1, 1, 32'(4 * i), 3'd2, 32'hA000_0000 + 32'(i), 1, 0, 0);
            else       go(0, 0, 0, 0, 0, 1, 0, 0);
            if (i >= 1 && i <= 4) begin
                chk("t2 nonseq", HTRANS, 2'b10);
                chk("t2 haddr", HADDR, 32'(4 * (i - 1)));
            end
            if (i >= 2 && i <= 5) chk("t2 hwdata", HWDATA, 32'hA000_0000 + 32'(i - 2));
            if (i >= 3) begin
                chk("t2 rsp_valid", rsp_valid, 1);
                chk("t2 rsp_rdata", rsp_rdata, 0);
            end
        end
        nop(1);

        // Size clamp and address alignment.
        go(1, 0, 32'h107, 3'd1, 0, 1, 0, 0);
        go(1, 0, 32'h13, 3'd5, 0, 1, 0, 0);
        chk("t3 haddr half", HADDR, 32'h106);
        chk("t3 hsize half", HSIZE, 3'd1);
        go(0, 0, 0, 0, 0, 1, 0, 0);
        chk("t3 haddr clamp", HADDR, 32'h10);
        chk("t3 hsize clamp", HSIZE, 3'd2);
        nop(3);

        // Read stalled 3 cycles with a write queued behind it.
        go(1, 0, 32'h40, 3'd2, 0, 1, 0, 0);
        go(1, 1, 32'h44, 3'd2, 32'h5555, 1, 0, 0);
        for (int k = 0; k < 4; k++) begin
            if (k < 3) go(0, 0, 0, 0, 0, 0, 0, 32'hBAD0BAD0);
            else       go(0, 0, 0, 0, 0, 1, 0, 32'h12345678);
            chk("t4 hold htrans", HTRANS, 2'b10);
            chk("t4 hold haddr", HADDR, 32'h44);
        end
        go(0, 0, 0, 0, 0, 1, 0, 0);
        chk("t4 read rsp", rsp_valid, 1);
        chk("t4 read rdata", rsp_rdata, 32'h12345678);
        chk("t4 write hwdata", HWDATA, 32'h5555);
        go(0, 0, 0, 0, 0, 1, 0, 0);
        chk("t4 write rsp", rsp_valid, 1);
        chk("t4 write rdata", rsp_rdata, 0);
        nop(2);

        // ERROR on a write while a read to 0x20 waits in the address phase.
        go(1, 1, 32'h30, 3'd2, 32'h77, 1, 0, 0);
        go(1, 0, 32'h20, 3'd2, 0, 1, 0, 0);
        go(0, 0, 0, 0, 0, 0, 1, 0);
        chk("t5 read nonseq", HTRANS, 2'b10);
        chk("t5 read haddr", HADDR, 32'h20);
        go(0, 0, 0, 0, 0, 1, 1, 0);
        chk("t5 idle in err", HTRANS, 2'b00);
        chk("t5 hsel in err", HSEL, 0);
        go(0, 0, 0, 0, 0, 1, 0, 0);
        chk("t5 reissue", HTRANS, 2'b10);
        chk("t5 reissue haddr", HADDR, 32'h20);
        chk("t5 err rsp", rsp_valid, 1);
        chk("t5 err flag", rsp_err, 1);
        go(0, 0, 0, 0, 0, 1, 0, 32'hCAFEF00D);
        chk("t5 gap", rsp_valid, 0);
        go(0, 0, 0, 0, 0, 1, 0, 0);
        chk("t5 read rsp", rsp_valid, 1);
        chk("t5 read ok", rsp_err, 0);
        chk("t5 read rdata", rsp_rdata, 32'hCAFEF00D);
        nop(2);

        // Watchdog: 20 wait cycles against a limit of 16.
        go(1, 0, 32'h50, 3'd0, 0, 1, 0, 0);
        go(0, 0, 0, 0, 0, 1, 0, 0);
        for (int k = 2; k < 22; k++) begin
            go(0, 0, 0, 0, 0, 0, 0, 0);
            if (k == 17) chk("t6 before limit", timeout, 0);
            if (k == 18) chk("t6 at limit", timeout, 1);
        end
        go(0, 0, 0, 0, 0, 1, 0, 32'h99);
        go(0, 0, 0, 0, 0, 1, 0, 0);
        chk("t6 rsp", rsp_valid, 1);
        chk("t6 rdata", rsp_rdata, 32'h99);
        go(0, 0, 0, 0, 0, 1, 0, 0);
        chk("t6 sticky", timeout, 1);

        // Reset with both slots occupied.
        go(1, 1, 32'h60, 3'd2, 32'h66, 1, 0, 0);
        go(1, 0, 32'h64, 3'd2, 0, 1, 0, 0);
        go(0, 0, 0, 0, 0, 0, 0, 0);
        chk("t7 busy before", busy, 1);
        @(posedge clk); #1;
        rstn = 1'b0;
        @(negedge clk);
        chk("t7 htrans", HTRANS, 0);
        chk("t7 busy", busy, 0);
        chk("t7 timeout", timeout, 0);
        @(posedge clk); #1;
        rstn = 1'b1; HREADY = 1'b1; cmd_valid = 1'b0;
        @(negedge clk);
        chk("t7 cmd_ready", cmd_ready, 1);
        chk("t7 no rsp", rsp_valid, 0);
        nop(4);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/ahb_cmd_master.md
# ahb_cmd_master

AHB-Lite single-master front end that turns a simple valid/ready command stream into AHB-Lite SINGLE transfers. It sits directly upstream of the AHB slave DUT, drives its HSEL/HADDR/HWRITE/HSIZE/HBURST/HPROT/HTRANS/HMASTLOCK/HWDATA and consumes HREADYOUT/HRESP/HRDATA. Address and data phases are pipelined, so back-to-back commands reach one transfer per cycle. Each completed data phase produces one in-order response.

## Interface
- ADDR_W, 32, HADDR and cmd_addr width
- DATA_W, 32, HWDATA/HRDATA width; legal values are 32 and 64
- WAIT_LIMIT, 16, number of consecutive HREADY-low data-phase cycles that sets `timeout`
- clk  in  1  single clock, rising edge; also drives HCLK
- rstn  in  1  asynchronous, active-low reset
- cmd_valid / cmd_ready  in/out  1  command handshake; transfer occurs when both are high
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  byte address; low bits below cmd_size are forced to 0
- cmd_size  in  3  HSIZE encoding; values above log2(DATA_W/8) are clamped to that value
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle pulse per completed transfer; no backpressure
- rsp_rdata  out  DATA_W  HRDATA for reads, 0 for writes
- rsp_err  out  1  transfer ended with an ERROR response
- HSEL  out  1  equal to HTRANS[1]
- HADDR  out  ADDR_W  address
- HWRITE  out  1  write flag
- HSIZE  out  3  size
- HBURST  out  3  constant 3'b000 (SINGLE)
- HPROT  out  4  constant 4'b0011
- HTRANS  out  2  IDLE (2'b00) or NONSEQ (2'b10) only
- HMASTLOCK  out  1  constant 0
- HWDATA  out  DATA_W  write data
- HREADY  in  1  slave HREADYOUT
- HRESP  in  1  0 = OKAY, 1 = ERROR
- HRDATA  in  DATA_W  read data
- busy  out  1  high while a command is held or a data phase is open
- timeout  out  1  sticky; cleared only by reset

## Operation
- Two slots:
  - **A slot:** holds the address-phase command and drives HADDR/HWRITE/HSIZE/HTRANS.
  - **D slot:** holds the data-phase write flag and wdata, and drives HWDATA.
- cmd_ready = !a_valid || (HREADY && !err_hold). An accepted command loads the A slot. HTRANS goes NONSEQ the next cycle.
- On an edge with HREADY=1:
  - The A slot moves to the D slot, or the D slot clears if the A slot is empty.
  - If d_valid was set, the response is registered: rsp_valid=1 the next cycle, rsp_err=HRESP, rsp_rdata = write ? 0 : HRDATA.
- Error handling:
  - An edge with HRESP=1 and HREADY=0 (first ERROR cycle) sets err_hold.
  - While err_hold is set, HTRANS is forced to IDLE and the A-slot command is retained (cancelled, not lost).
  - On the second ERROR cycle (HREADY=1), err_hold clears. The retained command is re-driven as NONSEQ the following cycle.
- With A empty, HTRANS=IDLE. HADDR, HWRITE and HSIZE hold their last values.
- Watchdog:
  - Counts consecutive cycles with d_valid=1 and HREADY=0.
  - When the count reaches WAIT_LIMIT, timeout sets. The transfer keeps waiting; there is no abort.
  - The counter clears on HREADY=1.
- Reset mid-transfer drops both slots and produces no response.

## Timing
- Reset values: HTRANS=IDLE, HSEL=0, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, timeout=0. cmd_ready=1 after reset deassertion.
- Zero-wait latency:
  - Accept at edge 0.
  - NONSEQ during cycle 0→1.
  - Data phase during cycle 1→2.
  - rsp_valid during cycle 2→3.
  - Total: 3 cycles from accept to response.
- Throughput: back-to-back commands with HREADY=1 give one NONSEQ and one rsp_valid per cycle.
- When HREADY=0, all AHB outputs and both slots hold.
- The cycle a retained command re-issues after an error, a new command may be accepted once that command advances.

## Structure
- `ahb_pkg` holds the shared definitions:
  - htrans_t with HTRANS_IDLE/BUSY/NONSEQ/SEQ
  - hsize_t
  - HBURST_SINGLE
  - HPROT_DEFAULT = 4'b0011
  - HRESP_OKAY/ERROR
- Sub-module `ahb_wait_watchdog` holds the WAIT_LIMIT counter and the sticky timeout flag.

## Test plan
- Single read, addr 0x0000_0010, size 2, HRDATA=0xDEAD_BEEF, zero wait → NONSEQ one cycle after accept; rsp_valid 3 cycles after accept with rsp_rdata=0xDEAD_BEEF and rsp_err=0.
- Four back-to-back writes to 0x00/0x04/0x08/0x0C, zero wait → four consecutive NONSEQ cycles; HWDATA lags HADDR by one cycle; four consecutive rsp_valid pulses with rsp_rdata=0.
- Read with HREADY low for 3 cycles and a queued write behind it → HADDR/HTRANS hold for the 3 cycles; the read response precedes the write response.
- ERROR on a write while a read to 0x20 is in the A slot → HTRANS=IDLE during the second ERROR cycle; the write responds with rsp_err=1; 0x20 is re-issued as NONSEQ the next cycle and completes OKAY.
- WAIT_LIMIT=16, HREADY held low for 20 cycles → timeout rises after 16 wait cycles and stays high after the transfer completes.
- Assert rstn low with both slots full → outputs return to reset values immediately; no rsp_valid; cmd_ready=1 after release.
